testbed_port_checker: RTL and testbench
=======================================

// Module: testbed_port_checker
// PURPOSE
//  Parametrised self-check monitor for CPU/cache system simulations.
//  Watches the core's data-memory write bus for stores to a dedicated test port.
//  After a begin symbol, compares each store against a loadable expected-value table.
//  Reports error count, run duration, first-mismatch capture, timeout and pass/fail.
//  Sits beside the DUT in the top-level bench; it replaces the fixed ROM checker.
// PARAMETERS
//  ADDR_W     30             width of word address bus
//  DATA_W     32             width of data bus (multiple of 8)
//  TEST_PORT  30'h3FF        word address of the test port
//  BEGIN_SYM  32'h00000168   store value that starts checking
//  END_SYM    32'hFFFFFD5D   store value that marks end of program output
//  CHECK_NUM  161            number of checked stores, END_SYM store included
//  IDX_W      10             width of check index; 2**IDX_W > CHECK_NUM
//  ERR_W      8              width of error counter
//  DUR_W      16             width of duration counter
//  TIMEOUT    16'hFFFF       CHECK-state cycle limit before forced report
//  BYTE_SWAP  1              1: byte-reverse data (little-endian bus); 0: as-is
// PORTS
//  clk             in   1        clock, rising edge
//  rst             in   1        synchronous reset, active-high
//  addr            in   ADDR_W   DUT data-memory word address
//  data            in   DATA_W   DUT store data
//  wen             in   1        DUT store enable
//  exp_we          in   1        expected-table write strobe
//  exp_addr        in   IDX_W    expected-table write index
//  exp_data        in   DATA_W   expected value, already in readable byte order
//  error_num       out  ERR_W    mismatch count; all-ones while idle
//  duration        out  DUR_W    cycles spent in CHECK
//  finish          out  1        high in REPORT
//  pass            out  1        finish & error_num==0 & !timeout & !short_run
//  timeout         out  1        run ended by TIMEOUT
//  short_run       out  1        END_SYM seen before index CHECK_NUM-1
//  first_err_vld   out  1        a mismatch has been captured
//  first_err_idx   out  IDX_W    index of first mismatch
//  first_err_data  out  DATA_W   received (swapped) data at first mismatch
// BEHAVIOUR
//  Reset (sync, any state, mid-run included): state=IDLE, idx=0, duration=0,
//   error_num=all-ones, all flags/captures=0, wen_q=0. Expected table NOT cleared.
//  data_m = BYTE_SWAP ? byte-reversed data : data.
//  wen_q <= wen every cycle. A store is accepted when wen & !wen_q & addr==TEST_PORT.
//   This is a rising-edge filter: a store held high across a D-cache stall counts once.
//  IDLE:   duration=0, idx=0. Accepted store with data_m==BEGIN_SYM -> CHECK and
//          error_num<=0. Other stores are ignored.
//  CHECK:  duration+1 each cycle, saturating at all-ones. On an accepted store:
//          compare data_m with exp[idx]. On mismatch, error_num+1, saturating at
//          all-ones. First mismatch latches first_err_vld/idx/data. idx<=idx+1.
//          If idx==CHECK_NUM-1 on that store -> REPORT on the same edge.
//          If data_m==END_SYM with idx<CHECK_NUM-1, the store is still compared;
//          then short_run<=1 -> REPORT.
//          If duration==TIMEOUT-1 with no terminating store -> timeout<=1 -> REPORT.
//          Terminating store and timeout on the same cycle: the store wins, timeout=0.
//  REPORT: all counters and captures hold. finish=1. Stores are ignored.
//          Leaves REPORT only via rst.
//  pass and finish are registered-state decodes; zero latency from state.
//  Result outputs change on the edge after an accepted store.
//  Expected table: CHECK_NUM x DATA_W array. exp_we writes exp[exp_addr] in any state.
//   exp_addr>=CHECK_NUM is dropped. A write to the index being compared in the
//   same cycle is not seen: the compare uses the old value.
//  Bench-only $display of PASS/FAIL is allowed inside a translate_off region.
// TESTING
//  1 Load exp[i]=i for i<160, exp[160]=END_SYM. Send BEGIN, then 0..159, then END_SYM,
//    byte-swapped -> finish=1, pass=1, error_num=0.
//  2 Same run, with each store held wen=1 for 3 cycles -> idx advances once per store;
//    pass=1.
//  3 Corrupt store idx 7 (send 99) and idx 20 -> error_num=2, first_err_idx=7,
//    first_err_data=99, pass=0.
//  4 BEGIN, then 10 good stores, then END_SYM -> short_run=1, finish=1, pass=0,
//    error_num=1.
//  5 TIMEOUT=50; BEGIN and no further stores -> REPORT with timeout=1, duration=50.
//  6 Assert rst mid-CHECK at idx 40 -> next cycle IDLE, error_num=8'hFF;
//    a fresh run then passes.

Source files
------------

// File: rtl/testbed_port_checker.sv
// testbed_port_checker: watches data-memory stores to a test port and checks them
// against a loadable expected-value table, reporting errors, duration and pass/fail.
`default_nettype none

module testbed_port_checker #(
   parameter int                  ADDR_W    = 30,
   parameter int                  DATA_W    = 32,
   parameter logic [ADDR_W-1:0]   TEST_PORT = 'h3FF,
   parameter logic [DATA_W-1:0]   BEGIN_SYM = 'h00000168,
   parameter logic [DATA_W-1:0]   END_SYM   = 'hFFFFFD5D,
   parameter int                  CHECK_NUM = 161,
   parameter int                  IDX_W     = 10,
   parameter int                  ERR_W     = 8,
   parameter int                  DUR_W     = 16,
   parameter logic [DUR_W-1:0]    TIMEOUT   = 'hFFFF,
   parameter bit                  BYTE_SWAP = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic              wen,
   input  logic              exp_we,
   input  logic [IDX_W-1:0]  exp_addr,
   input  logic [DATA_W-1:0] exp_data,
   output logic [ERR_W-1:0]  error_num,
   output logic [DUR_W-1:0]  duration,
   output logic              finish,
   output logic              pass,
   output logic              timeout,
   output logic              short_run,
   output logic              first_err_vld,
   output logic [IDX_W-1:0]  first_err_idx,
   output logic [DATA_W-1:0] first_err_data
);

   localparam int               c_NBYTES    = DATA_W / 8;
   localparam int               c_AW        = (CHECK_NUM > 1) ? $clog2(CHECK_NUM) : 1;
   localparam logic [IDX_W-1:0] c_CHECK_NUM = IDX_W'(CHECK_NUM);
   localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(CHECK_NUM - 1);
   localparam logic [DUR_W-1:0] c_TO_LAST   = TIMEOUT - 1'b1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CHECK  = 2'd1,
      S_REPORT = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic                r_wen_q;
   logic [IDX_W-1:0]    r_idx, w_idx_nxt;
   logic [ERR_W-1:0]    r_err, w_err_nxt;
   logic [DUR_W-1:0]    r_dur, w_dur_nxt;
   logic                r_timeout, w_timeout_nxt;
   logic                r_short, w_short_nxt;
   logic                r_fe_vld, w_fe_vld_nxt;
   logic [IDX_W-1:0]    r_fe_idx, w_fe_idx_nxt;
   logic [DATA_W-1:0]   r_fe_data, w_fe_data_nxt;

   logic [DATA_W-1:0]   w_data_m;
   logic [DATA_W-1:0]   w_exp_rd;
   logic                w_accept;
   logic                w_term;
   logic [DATA_W-1:0]   r_exp [CHECK_NUM];

   generate
      if (BYTE_SWAP) begin : g_swap
         for (genvar b = 0; b < c_NBYTES; b++) begin : g_byte
            assign w_data_m[8*b +: 8] = data[DATA_W-8-8*b +: 8];
         end
      end else begin : g_noswap
         assign w_data_m = data;
      end
   endgenerate

   // Rising-edge filter: a store held across a stall is counted once.
   assign w_accept = wen && !r_wen_q && (addr == TEST_PORT);
   assign w_exp_rd = r_exp[r_idx[c_AW-1:0]];
   assign w_term   = w_accept && ((r_idx == c_LAST_IDX) || (w_data_m == END_SYM));

   // Table is deliberately not reset so it can be loaded before or after rst.
   always_ff @(posedge clk) begin
      if (exp_we && (exp_addr < c_CHECK_NUM)) begin
         r_exp[exp_addr[c_AW-1:0]] <= exp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_wen_q   <= 1'b0;
         r_idx     <= '0;
         r_err     <= '1;
         r_dur     <= '0;
         r_timeout <= 1'b0;
         r_short   <= 1'b0;
         r_fe_vld  <= 1'b0;
         r_fe_idx  <= '0;
         r_fe_data <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_wen_q   <= wen;
         r_idx     <= w_idx_nxt;
         r_err     <= w_err_nxt;
         r_dur     <= w_dur_nxt;
         r_timeout <= w_timeout_nxt;
         r_short   <= w_short_nxt;
         r_fe_vld  <= w_fe_vld_nxt;
         r_fe_idx  <= w_fe_idx_nxt;
         r_fe_data <= w_fe_data_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_err_nxt     = r_err;
      w_dur_nxt     = r_dur;
      w_timeout_nxt = r_timeout;
      w_short_nxt   = r_short;
      w_fe_vld_nxt  = r_fe_vld;
      w_fe_idx_nxt  = r_fe_idx;
      w_fe_data_nxt = r_fe_data;
      case (r_state)
         S_IDLE: begin
            w_dur_nxt = '0;
            w_idx_nxt = '0;
            if (w_accept && (w_data_m == BEGIN_SYM)) begin
               w_state_nxt = S_CHECK;
               w_err_nxt   = '0;
            end
         end
         S_CHECK: begin
            if (r_dur != '1) begin
               w_dur_nxt = r_dur + 1'b1;
            end
            if (w_accept) begin
               w_idx_nxt = r_idx + 1'b1;
               if (w_data_m != w_exp_rd) begin
                  if (r_err != '1) begin
                     w_err_nxt = r_err + 1'b1;
                  end
                  if (!r_fe_vld) begin
                     w_fe_vld_nxt  = 1'b1;
                     w_fe_idx_nxt  = r_idx;
                     w_fe_data_nxt = w_data_m;
                  end
               end
               if (r_idx == c_LAST_IDX) begin
                  w_state_nxt = S_REPORT;
               end else if (w_data_m == END_SYM) begin
                  w_short_nxt = 1'b1;
                  w_state_nxt = S_REPORT;
               end
            end
            // A terminating store on the timeout cycle takes priority.
            if (!w_term && (r_dur == c_TO_LAST)) begin
               w_timeout_nxt = 1'b1;
               w_state_nxt   = S_REPORT;
            end
         end
         S_REPORT: begin
            w_state_nxt = S_REPORT;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign error_num      = r_err;
   assign duration       = r_dur;
   assign finish         = (r_state == S_REPORT);
   assign pass           = finish && (r_err == '0) && !r_timeout && !r_short;
   assign timeout        = r_timeout;
   assign short_run      = r_short;
   assign first_err_vld  = r_fe_vld;
   assign first_err_idx  = r_fe_idx;
   assign first_err_data = r_fe_data;

endmodule

`default_nettype wire

// File: tb/tb_testbed_port_checker.sv
// Directed self-checking bench for testbed_port_checker (default and short-timeout builds).
`default_nettype none

module tb_testbed_port_checker;

   localparam logic [29:0] TP      = 30'h3FF;
   localparam logic [31:0] BEG     = 32'h00000168;
   localparam logic [31:0] ENDS    = 32'hFFFFFD5D;

   logic        clk = 1'b0;
   logic        rst;
   logic [29:0] addr;
   logic [31:0] data;
   logic        wen;
   logic        exp_we;
   logic [9:0]  exp_addr;
   logic [31:0] exp_data;

   logic [7:0]  error_num, to_error_num;
   logic [15:0] duration, to_duration;
   logic        finish, pass, timeout, short_run, first_err_vld;
   logic        to_finish, to_pass, to_timeout, to_short_run, to_first_err_vld;
   logic [9:0]  first_err_idx, to_first_err_idx;
   logic [31:0] first_err_data, to_first_err_data;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   testbed_port_checker dut (
      .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
      .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
      .error_num(error_num), .duration(duration), .finish(finish), .pass(pass),
      .timeout(timeout), .short_run(short_run), .first_err_vld(first_err_vld),
      .first_err_idx(first_err_idx), .first_err_data(first_err_data)
   );

   testbed_port_checker #(.TIMEOUT(16'd50)) dut_to (
      .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
      .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
      .error_num(to_error_num), .duration(to_duration), .finish(to_finish), .pass(to_pass),
      .timeout(to_timeout), .short_run(to_short_run), .first_err_vld(to_first_err_vld),
      .first_err_idx(to_first_err_idx), .first_err_data(to_first_err_data)
   );

   function automatic logic [31:0] bswap(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic write_exp(input logic [9:0] a, input logic [31:0] d);
      @(negedge clk);
      exp_we = 1'b1; exp_addr = a; exp_data = d;
      @(negedge clk);
      exp_we = 1'b0;
   endtask

   // One store to address a, held for 'hold' cycles, then one idle cycle.
   // If poke >= 0, the expected table entry 'poke' is overwritten on the store edge.
   task automatic store(input logic [31:0] val, input int hold, input logic [29:0] a,
                        input int poke);
      @(negedge clk);
      addr = a; data = bswap(val); wen = 1'b1;
      if (poke >= 0) begin
         exp_we = 1'b1; exp_addr = 10'(poke); exp_data = 32'hDEAD_BEEF;
      end
      repeat (hold - 1) @(negedge clk);
      @(negedge clk);
      wen = 1'b0; exp_we = 1'b0;
   endtask

   task automatic send_run(input int n_good, input int hold, input bit corrupt, input int poke);
      logic [31:0] v;
      store(BEG, hold, TP, -1);
      for (int i = 0; i < n_good; i++) begin
         v = 32'(i);
         if (corrupt && i == 7)  v = 32'd99;
         if (corrupt && i == 20) v = 32'h1234;
         store(v, hold, TP, (i == poke) ? poke : -1);
      end
      store(ENDS, hold, TP, -1);
   endtask

   initial begin
      rst = 1'b1; addr = '0; data = '0; wen = 1'b0;
      exp_we = 1'b0; exp_addr = '0; exp_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_err",   32'(error_num), 32'hFF);
      check("rst_fin",   32'(finish), 32'd0);
      check("rst_pass",  32'(pass), 32'd0);
      check("rst_dur",   32'(duration), 32'd0);
      check("rst_flags", {29'd0, first_err_vld, timeout, short_run}, 32'd0);

      // BEGIN to a neighbouring address must not start a run
      store(BEG, 1, TP + 30'd1, -1);
      check("ign_addr_err", 32'(error_num), 32'hFF);
      check("ign_addr_fin", 32'(finish), 32'd0);

      for (int i = 0; i < 160; i++) write_exp(10'(i), 32'(i));
      write_exp(10'd160, ENDS);
      // Out-of-range index that would alias entry 3 if not dropped
      write_exp(10'd259, 32'hBAD0_0003);

      // Test 1: full good run; table entry 5 rewritten on its own compare edge
      send_run(160, 1, 1'b0, 5);
      check("t1_fin",  32'(finish), 32'd1);
      check("t1_pass", 32'(pass), 32'd1);
      check("t1_err",  32'(error_num), 32'd0);
      check("t1_dur",  32'(duration), 32'd322);
      check("t1_vld",  32'(first_err_vld), 32'd0);
      store(32'd77, 1, TP, -1);
      check("t1_rep_err", 32'(error_num), 32'd0);
      check("t1_rep_dur", 32'(duration), 32'd322);
      write_exp(10'd5, 32'd5);

      // Test 2: stores held for 3 cycles
      do_reset();
      check("t2_rst_err", 32'(error_num), 32'hFF);
      send_run(160, 3, 1'b0, -1);
      check("t2_pass", 32'(pass), 32'd1);
      check("t2_err",  32'(error_num), 32'd0);
      check("t2_dur",  32'(duration), 32'd644);

      // Test 3: corrupted stores at index 7 and 20
      do_reset();
      send_run(160, 1, 1'b1, -1);
      check("t3_fin",   32'(finish), 32'd1);
      check("t3_err",   32'(error_num), 32'd2);
      check("t3_vld",   32'(first_err_vld), 32'd1);
      check("t3_fidx",  32'(first_err_idx), 32'd7);
      check("t3_fdata", first_err_data, 32'd99);
      check("t3_pass",  32'(pass), 32'd0);

      // Test 4: early END_SYM
      do_reset();
      send_run(10, 1, 1'b0, -1);
      check("t4_short", 32'(short_run), 32'd1);
      check("t4_fin",   32'(finish), 32'd1);
      check("t4_pass",  32'(pass), 32'd0);
      check("t4_err",   32'(error_num), 32'd1);
      check("t4_fidx",  32'(first_err_idx), 32'd10);
      check("t4_fdata", first_err_data, ENDS);
      check("t4_to",    32'(timeout), 32'd0);

      // Test 5: timeout (TIMEOUT=50 instance)
      do_reset();
      store(BEG, 1, TP, -1);
      repeat (60) @(negedge clk);
      check("t5_to",    32'(to_timeout), 32'd1);
      check("t5_dur",   32'(to_duration), 32'd50);
      check("t5_fin",   32'(to_finish), 32'd1);
      check("t5_pass",  32'(to_pass), 32'd0);
      check("t5_err",   32'(to_error_num), 32'd0);
      check("t5_def_fin", 32'(finish), 32'd0);

      // Test 6: reset mid-run at index 40, then a fresh run
      do_reset();
      store(BEG, 1, TP, -1);
      for (int i = 0; i < 40; i++) store(32'(i), 1, TP, -1);
      check("t6_mid_fin", 32'(finish), 32'd0);
      check("t6_mid_err", 32'(error_num), 32'd0);
      do_reset();
      check("t6_rst_err", 32'(error_num), 32'hFF);
      check("t6_rst_dur", 32'(duration), 32'd0);
      check("t6_rst_fin", 32'(finish), 32'd0);
      send_run(160, 1, 1'b0, -1);
      check("t6_pass", 32'(pass), 32'd1);
      check("t6_err",  32'(error_num), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
